// File: rtl/vmem_pkg.sv
// rtl/vmem_pkg.sv - slot word layout and requester ids for the video SRAM slot scheduler
package vmem_pkg;

   localparam int SLOT_OP    = 0;
   localparam int SLOT_ID_LO = 2;
   localparam int SLOT_ID_HI = 3;
   localparam int SLOT_NOP   = 7;

   localparam logic [7:0] SLOT_IDLE = 8'h80;

   localparam logic [1:0] REQ_VID0 = 2'd0;
   localparam logic [1:0] REQ_VID1 = 2'd1;
   localparam logic [1:0] REQ_CPU  = 2'd2;
   localparam logic [1:0] REQ_BLIT = 2'd3;

   typedef logic [7:0] slot_word_t;

   function automatic logic [1:0] slot_id(input slot_word_t s);
      return s[SLOT_ID_HI:SLOT_ID_LO];
   endfunction

endpackage

// File: rtl/vmem_slot_table.sv
// rtl/vmem_slot_table.sv - double-buffered slot table; shadow is copied to active only on table wrap
module vmem_slot_table
   import vmem_pkg::*;
#(
   parameter int TSSIZE = 8,
   parameter int TSIDX  = $clog2(TSSIZE)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_cfg_we,
   input  logic [TSIDX-1:0] i_cfg_idx,
   input  logic [7:0]       i_cfg_slot,
   input  logic             i_cfg_commit,
   input  logic             i_wrap,
   input  logic [TSIDX-1:0] i_rd_idx,
   output slot_word_t       o_rd_slot,
   output logic             o_pending
);

   logic [TSSIZE-1:0][7:0] r_shadow;
   logic [TSSIZE-1:0][7:0] r_active;
   logic                   r_pending;

   // Swap copies the pre-edge shadow; a commit on the wrap edge re-arms for the next wrap.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shadow  <= {TSSIZE{SLOT_IDLE}};
         r_active  <= {TSSIZE{SLOT_IDLE}};
         r_pending <= 1'b0;
      end else begin
         if (i_cfg_we)
            r_shadow[i_cfg_idx] <= i_cfg_slot;
         if (i_wrap && r_pending)
            r_active <= r_shadow;
         if (i_cfg_commit)
            r_pending <= 1'b1;
         else if (i_wrap)
            r_pending <= 1'b0;
      end
   end

   assign o_rd_slot = r_active[i_rd_idx];
   assign o_pending = r_pending;

endmodule

// File: rtl/vmem_slot_sched.sv
// rtl/vmem_slot_sched.sv - two-clock-per-slot TDM scheduler for the shared single-port video SRAM
module vmem_slot_sched
   import vmem_pkg::*;
#(
   parameter int AWIDTH = 19,
   parameter int DWIDTH = 8,
   parameter int TSSIZE = 8,
   parameter int TSIDX  = $clog2(TSSIZE)
) (
   input  logic                MemClk,
   input  logic                MemRstN,
   input  logic [3:0]          i_ReqValid,
   input  logic [3:0]          i_ReqWrite,
   input  logic [4*AWIDTH-1:0] i_ReqAddr,
   input  logic [4*DWIDTH-1:0] i_ReqWData,
   output logic [3:0]          o_ReqAck,
   output logic [DWIDTH-1:0]   o_RspData,
   output logic [3:0]          o_RspValid,
   input  logic                i_CfgWe,
   input  logic [TSIDX-1:0]    i_CfgIdx,
   input  logic [7:0]          i_CfgSlot,
   input  logic                i_CfgCommit,
   output logic                o_CfgPending,
   output logic [AWIDTH-1:0]   o_MemAddrPort,
   output logic [DWIDTH-1:0]   o_MemDataOut,
   output logic                o_MemDataOe,
   input  logic [DWIDTH-1:0]   i_MemDataIn,
   output logic                o_MemWriteEnable,
   output logic                o_MemOutputEnable
);

   logic              r_phase;
   logic [TSIDX-1:0]  r_slot_idx;
   logic [1:0]        r_cur_id;
   logic              r_cur_op;
   logic              r_cur_active;
   logic [3:0]        r_ack;
   logic [3:0]        r_rsp_valid;
   logic [DWIDTH-1:0] r_rsp_data;
   logic [AWIDTH-1:0] r_addr;
   logic [DWIDTH-1:0] r_dout;
   logic              r_data_oe;
   logic              r_we_n;
   logic              r_oe_n;

   slot_word_t        w_slot;
   logic [1:0]        w_id;
   logic              w_op;
   logic              w_eligible;
   logic              w_wrap;
   logic [AWIDTH-1:0] w_req_addr;
   logic [DWIDTH-1:0] w_req_wdata;
   logic              w_unused;

   assign w_wrap = r_phase && (r_slot_idx == TSIDX'(TSSIZE - 1));

   vmem_slot_table #(
      .TSSIZE (TSSIZE),
      .TSIDX  (TSIDX)
   ) u_table (
      .i_clk        (MemClk),
      .i_rst_n      (MemRstN),
      .i_cfg_we     (i_CfgWe),
      .i_cfg_idx    (i_CfgIdx),
      .i_cfg_slot   (i_CfgSlot),
      .i_cfg_commit (i_CfgCommit),
      .i_wrap       (w_wrap),
      .i_rd_idx     (r_slot_idx),
      .o_rd_slot    (w_slot),
      .o_pending    (o_CfgPending)
   );

   assign w_id        = slot_id(w_slot);
   assign w_op        = w_slot[SLOT_OP];
   assign w_req_addr  = i_ReqAddr[w_id*AWIDTH +: AWIDTH];
   assign w_req_wdata = i_ReqWData[w_id*DWIDTH +: DWIDTH];
   // A request whose direction differs from the slot's op is left waiting, never converted.
   assign w_eligible  = !w_slot[SLOT_NOP] && i_ReqValid[w_id] && (i_ReqWrite[w_id] == w_op);
   assign w_unused    = ^{w_slot[6:4], w_slot[1]};

   always_ff @(posedge MemClk or negedge MemRstN) begin
      if (!MemRstN) begin
         r_phase      <= 1'b0;
         r_slot_idx   <= '0;
         r_cur_id     <= 2'd0;
         r_cur_op     <= 1'b0;
         r_cur_active <= 1'b0;
         r_ack        <= 4'b0000;
         r_rsp_valid  <= 4'b0000;
         r_rsp_data   <= '0;
         r_addr       <= '0;
         r_dout       <= '0;
         r_data_oe    <= 1'b0;
         r_we_n       <= 1'b1;
         r_oe_n       <= 1'b1;
      end else if (!r_phase) begin
         r_phase     <= 1'b1;
         r_rsp_valid <= 4'b0000;
         if (w_eligible) begin
            r_addr       <= w_req_addr;
            r_ack        <= 4'b0001 << w_id;
            r_cur_id     <= w_id;
            r_cur_op     <= w_op;
            r_cur_active <= 1'b1;
            if (w_op) begin
               r_dout    <= w_req_wdata;
               r_data_oe <= 1'b1;
               r_we_n    <= 1'b0;
            end else begin
               r_oe_n    <= 1'b0;
               r_data_oe <= 1'b0;
            end
         end else begin
            r_cur_active <= 1'b0;
            r_data_oe    <= 1'b0;
         end
      end else begin
         // Data bus drive is kept until the next setup edge so write data holds past WE rise.
         r_phase    <= 1'b0;
         r_ack      <= 4'b0000;
         r_we_n     <= 1'b1;
         r_oe_n     <= 1'b1;
         r_slot_idx <= r_slot_idx + 1'b1;
         if (r_cur_active && !r_cur_op) begin
            r_rsp_data  <= i_MemDataIn;
            r_rsp_valid <= 4'b0001 << r_cur_id;
         end
      end
   end

   assign o_ReqAck          = r_ack;
   assign o_RspData         = r_rsp_data;
   assign o_RspValid        = r_rsp_valid;
   assign o_MemAddrPort     = r_addr;
   assign o_MemDataOut      = r_dout;
   assign o_MemDataOe       = r_data_oe;
   assign o_MemWriteEnable  = r_we_n;
   assign o_MemOutputEnable = r_oe_n;

endmodule

// File: tb/tb_vmem_slot_sched.sv
// tb/tb_vmem_slot_sched.sv - randomized slot-level reference model bench for vmem_slot_sched
module tb_vmem_slot_sched;
   import vmem_pkg::*;

   localparam int AW = 19;
   localparam int DW = 8;
   localparam int TS = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [3:0]     req_valid = '0;
   logic [3:0]     req_write = '0;
   logic [4*AW-1:0] req_addr = '0;
   logic [4*DW-1:0] req_wdata = '0;
   logic           cfg_we = 1'b0;
   logic [2:0]     cfg_idx = '0;
   logic [7:0]     cfg_slot = '0;
   logic           cfg_commit = 1'b0;
   logic [DW-1:0]  mem_din = '0;

   logic [3:0]     ack, rsp_valid;
   logic [DW-1:0]  rsp_data, mem_dout;
   logic           cfg_pending, data_oe, we_n, oe_n;
   logic [AW-1:0]  mem_addr;

   always #5 clk = ~clk;

   vmem_slot_sched #(.AWIDTH(AW), .DWIDTH(DW), .TSSIZE(TS)) dut (
      .MemClk(clk), .MemRstN(rst_n),
      .i_ReqValid(req_valid), .i_ReqWrite(req_write), .i_ReqAddr(req_addr), .i_ReqWData(req_wdata),
      .o_ReqAck(ack), .o_RspData(rsp_data), .o_RspValid(rsp_valid),
      .i_CfgWe(cfg_we), .i_CfgIdx(cfg_idx), .i_CfgSlot(cfg_slot), .i_CfgCommit(cfg_commit),
      .o_CfgPending(cfg_pending), .o_MemAddrPort(mem_addr), .o_MemDataOut(mem_dout),
      .o_MemDataOe(data_oe), .i_MemDataIn(mem_din),
      .o_MemWriteEnable(we_n), .o_MemOutputEnable(oe_n)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: slot tables, wrap-time swap and registered SRAM-side values.
   logic [7:0]  m_active [TS];
   logic [7:0]  m_shadow [TS];
   bit          m_pending;
   int          m_sidx;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_dout, m_rsp;
   bit          m_data_oe;

   bit          h_valid [4];
   bit          h_write [4];
   logic [AW-1:0] h_addr [4];
   logic [DW-1:0] h_wdata [4];

   bit          c0_we, c0_commit, c1_we, c1_commit;
   logic [2:0]  c0_idx, c1_idx;
   logic [7:0]  c0_slot, c1_slot;
   bit          din_force;
   logic [DW-1:0] din_val;
   int          ack_cnt [4];

   task automatic model_reset();
      for (int i = 0; i < TS; i++) begin
         m_active[i] = 8'h80;
         m_shadow[i] = 8'h80;
      end
      m_pending = 0; m_sidx = 0; m_addr = '0; m_dout = '0; m_rsp = '0; m_data_oe = 0;
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < 4; i++) begin
         req_valid[i] = h_valid[i];
         req_write[i] = h_write[i];
         req_addr[i*AW +: AW] = h_addr[i];
         req_wdata[i*DW +: DW] = h_wdata[i];
      end
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < 4; i++) h_valid[i] = 0;
      for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
   endtask

   task automatic set_req(input int id, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      h_valid[id] = 1; h_write[id] = wr; h_addr[id] = a; h_wdata[id] = d;
   endtask

   task automatic do_slot();
      logic [7:0] s;
      logic [1:0] id;
      bit elig, rd, wr, wrap;
      logic [3:0] exp_ack, exp_rv;
      logic [7:0] pre_sh [TS];
      s = m_active[m_sidx];
      id = s[3:2];
      elig = !s[7] && h_valid[id] && (h_write[id] == s[0]);
      wr = elig && s[0];
      rd = elig && !s[0];
      exp_ack = elig ? (4'b0001 << id) : 4'b0000;
      if (elig) m_addr = h_addr[id];
      if (wr) m_dout = h_wdata[id];
      m_data_oe = wr;
      drive_reqs();
      cfg_we = c0_we; cfg_idx = c0_idx; cfg_slot = c0_slot; cfg_commit = c0_commit;
      if (c0_we) m_shadow[c0_idx] = c0_slot;
      if (c0_commit) m_pending = 1;
      @(posedge clk); #1;
      n_checks++; if (ack !== exp_ack) begin n_fail++; $display("FAIL setup_ack slot%0d: got %b expected %b", m_sidx, ack, exp_ack); end
      n_checks++; if (we_n !== !wr) begin n_fail++; $display("FAIL setup_we slot%0d: got %b expected %b", m_sidx, we_n, !wr); end
      n_checks++; if (oe_n !== !rd) begin n_fail++; $display("FAIL setup_oe slot%0d: got %b expected %b", m_sidx, oe_n, !rd); end
      n_checks++; if (data_oe !== m_data_oe) begin n_fail++; $display("FAIL setup_data_oe slot%0d: got %b expected %b", m_sidx, data_oe, m_data_oe); end
      n_checks++; if (mem_addr !== m_addr) begin n_fail++; $display("FAIL setup_addr slot%0d: got %h expected %h", m_sidx, mem_addr, m_addr); end
      n_checks++; if (mem_dout !== m_dout) begin n_fail++; $display("FAIL setup_dout slot%0d: got %h expected %h", m_sidx, mem_dout, m_dout); end
      n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL setup_rsp_valid slot%0d: got %b expected 0000", m_sidx, rsp_valid); end
      n_checks++; if (cfg_pending !== m_pending) begin n_fail++; $display("FAIL setup_pending slot%0d: got %b expected %b", m_sidx, cfg_pending, m_pending); end
      for (int i = 0; i < 4; i++) if (ack[i] === 1'b1) ack_cnt[i]++;
      if (elig) h_valid[id] = 0;
      drive_reqs();
      mem_din = din_force ? din_val : DW'($urandom);
      cfg_we = c1_we; cfg_idx = c1_idx; cfg_slot = c1_slot; cfg_commit = c1_commit;
      wrap = (m_sidx == TS - 1);
      pre_sh = m_shadow;
      if (c1_we) m_shadow[c1_idx] = c1_slot;
      if (wrap && m_pending) m_active = pre_sh;
      if (c1_commit) m_pending = 1;
      else if (wrap) m_pending = 0;
      exp_rv = rd ? exp_ack : 4'b0000;
      if (rd) m_rsp = mem_din;
      @(posedge clk); #1;
      n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL complete_ack slot%0d: got %b expected 0000", m_sidx, ack); end
      n_checks++; if ({we_n, oe_n} !== 2'b11) begin n_fail++; $display("FAIL complete_strobes slot%0d: got %b expected 11", m_sidx, {we_n, oe_n}); end
      n_checks++; if (data_oe !== m_data_oe) begin n_fail++; $display("FAIL complete_data_oe slot%0d: got %b expected %b", m_sidx, data_oe, m_data_oe); end
      n_checks++; if (rsp_valid !== exp_rv) begin n_fail++; $display("FAIL rsp_valid slot%0d: got %b expected %b", m_sidx, rsp_valid, exp_rv); end
      n_checks++; if (rsp_data !== m_rsp) begin n_fail++; $display("FAIL rsp_data slot%0d: got %h expected %h", m_sidx, rsp_data, m_rsp); end
      n_checks++; if (cfg_pending !== m_pending) begin n_fail++; $display("FAIL complete_pending slot%0d: got %b expected %b", m_sidx, cfg_pending, m_pending); end
      m_sidx = (m_sidx + 1) % TS;
      c0_we = 0; c0_commit = 0; c1_we = 0; c1_commit = 0;
      cfg_we = 0; cfg_commit = 0;
   endtask

   task automatic run_to(input int idx);
      for (int n = 0; n < 2 * TS && m_sidx != idx; n++) do_slot();
   endtask

   task automatic program_table(input logic [7:0] words [TS]);
      run_to(0);
      for (int i = 0; i < TS; i++) begin
         c0_we = 1; c0_idx = 3'(i); c0_slot = words[i];
         c0_commit = (i == TS - 1);
         do_slot();
      end
      for (int n = 0; n < 2 * TS && (m_pending || m_sidx != 0); n++) do_slot();
   endtask

   task automatic test_reset();
      model_reset();
      clear_reqs();
      #12;
      n_checks++; if ({we_n, oe_n, data_oe} !== 3'b110) begin n_fail++; $display("FAIL reset_strobes: got %b expected 110", {we_n, oe_n, data_oe}); end
      n_checks++; if ({ack, rsp_valid, cfg_pending} !== 9'd0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0", {ack, rsp_valid, cfg_pending}); end
      n_checks++; if ({mem_addr, mem_dout, rsp_data} !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_dout, rsp_data}); end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_all_nop();
      set_req(REQ_VID0, 0, 19'h00042, 8'h00);
      for (int n = 0; n < 2 * TS; n++) do_slot();
      n_checks++; if (ack_cnt[0] !== 0) begin n_fail++; $display("FAIL nop_table_acks: got %0d expected 0", ack_cnt[0]); end
      clear_reqs();
   endtask

   task automatic test_read_write();
      logic [7:0] t [TS];
      for (int i = 0; i < TS; i++) t[i] = SLOT_IDLE;
      t[0] = 8'h00; t[1] = 8'h09;
      program_table(t);
      set_req(REQ_VID0, 0, 19'h12345, 8'h00);
      set_req(REQ_CPU, 1, 19'h00010, 8'h3C);
      din_force = 1; din_val = 8'hA5;
      do_slot();
      din_force = 0;
      n_checks++; if (rsp_data !== 8'hA5) begin n_fail++; $display("FAIL read_data: got %h expected a5", rsp_data); end
      n_checks++; if (ack_cnt[0] !== 1) begin n_fail++; $display("FAIL read_ack_count: got %0d expected 1", ack_cnt[0]); end
      do_slot();
      n_checks++; if ({mem_dout, data_oe} !== {8'h3C, 1'b1}) begin n_fail++; $display("FAIL write_hold: got %h/%b expected 3c/1", mem_dout, data_oe); end
      n_checks++; if (ack_cnt[2] !== 1) begin n_fail++; $display("FAIL write_ack_count: got %0d expected 1", ack_cnt[2]); end
      clear_reqs();
   endtask

   task automatic test_op_mismatch();
      set_req(REQ_VID0, 1, 19'h00777, 8'h55);
      for (int n = 0; n < 2 * TS; n++) do_slot();
      n_checks++; if (ack_cnt[0] !== 0) begin n_fail++; $display("FAIL mismatch_acks: got %0d expected 0", ack_cnt[0]); end
      clear_reqs();
   endtask

   task automatic test_commit_mid();
      run_to(3);
      set_req(REQ_VID1, 0, 19'h0ABCD, 8'h00);
      c0_we = 1; c0_idx = 3'd5; c0_slot = 8'h04; c0_commit = 1;
      for (int n = 0; n < 5; n++) do_slot();
      n_checks++; if (ack_cnt[1] !== 0) begin n_fail++; $display("FAIL commit_old_table_acks: got %0d expected 0", ack_cnt[1]); end
      for (int n = 0; n < 6; n++) do_slot();
      n_checks++; if (ack_cnt[1] !== 1) begin n_fail++; $display("FAIL commit_new_table_acks: got %0d expected 1", ack_cnt[1]); end
      clear_reqs();
   endtask

   task automatic test_commit_on_wrap();
      run_to(7);
      set_req(REQ_BLIT, 0, 19'h00300, 8'h00);
      c0_we = 1; c0_idx = 3'd6; c0_slot = 8'h0C;
      c1_commit = 1;
      do_slot();
      n_checks++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL wrap_commit_pending: got %b expected 1", cfg_pending); end
      for (int n = 0; n < TS; n++) do_slot();
      n_checks++; if (ack_cnt[3] !== 0) begin n_fail++; $display("FAIL wrap_commit_early_acks: got %0d expected 0", ack_cnt[3]); end
      for (int n = 0; n < TS; n++) do_slot();
      n_checks++; if (ack_cnt[3] !== 1) begin n_fail++; $display("FAIL wrap_commit_late_acks: got %0d expected 1", ack_cnt[3]); end
      clear_reqs();
   endtask

   task automatic test_random();
      logic [7:0] t [TS];
      for (int i = 0; i < TS; i++) t[i] = 8'($urandom);
      program_table(t);
      for (int n = 0; n < 6 * TS; n++) begin
         for (int i = 0; i < 4; i++)
            if (!h_valid[i] && $urandom_range(0, 1) == 1)
               set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
         if ($urandom_range(0, 5) == 0) begin
            c0_we = 1; c0_idx = 3'($urandom_range(0, TS - 1)); c0_slot = 8'($urandom);
         end
         if ($urandom_range(0, 7) == 0) begin
            c1_we = 1; c1_idx = 3'($urandom_range(0, TS - 1)); c1_slot = 8'($urandom);
            c1_commit = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 9) == 0) c0_commit = 1;
         do_slot();
      end
      clear_reqs();
   endtask

   task automatic test_reset_mid_write();
      logic [7:0] t [TS];
      for (int i = 0; i < TS; i++) t[i] = SLOT_IDLE;
      t[1] = 8'h09;
      program_table(t);
      do_slot();
      set_req(REQ_CPU, 1, 19'h01234, 8'h99);
      drive_reqs();
      @(posedge clk); #1;
      n_checks++; if (we_n !== 1'b0) begin n_fail++; $display("FAIL pre_reset_we: got %b expected 0", we_n); end
      rst_n = 1'b0;
      #1;
      n_checks++; if ({we_n, oe_n, data_oe} !== 3'b110) begin n_fail++; $display("FAIL async_reset_strobes: got %b expected 110", {we_n, oe_n, data_oe}); end
      n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL async_reset_ack: got %b expected 0000", ack); end
      @(posedge clk); @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
      for (int n = 0; n < 2 * TS; n++) do_slot();
      n_checks++; if (ack_cnt[2] !== 0) begin n_fail++; $display("FAIL post_reset_acks: got %0d expected 0", ack_cnt[2]); end
      clear_reqs();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_all_nop();
      test_read_write();
      test_op_mismatch();
      test_commit_mid();
      test_commit_on_wrap();
      test_random();
      test_reset_mid_write();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
